// File: rtl/jvs_feature_parser.sv
// rtl/jvs_feature_parser.sv - JVS Feature Check (0x14) payload decoder producing one node capability record
//
// Ports:
//   clk, rst            single clock; rst is synchronous active-high
//   start, node_idx_i   begin a new parse (clears record and errors), capture node index
//   in_valid, in_data,
//   in_last, in_ready   payload byte stream (status/report bytes already stripped)
//   node_idx            index captured at start
//   done                one-cycle pulse when the parse finishes
//   err_unknown         an unrecognised function code was seen
//   err_trunc           payload ended before the 0x00 terminator
//   err_ovf             more than MAX_FUNCS function entries
//   players .. has_backup  decoded capability record, held until next start/rst

module jvs_feature_parser #(
    parameter int MAX_FUNCS = 16,
    parameter int IDX_W     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] node_idx_i,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [IDX_W-1:0] node_idx,
    output logic             done,
    output logic             err_unknown,
    output logic             err_trunc,
    output logic             err_ovf,
    output logic [3:0]       players,
    output logic [7:0]       buttons,
    output logic [3:0]       coin_slots,
    output logic [3:0]       analog_channels,
    output logic [7:0]       analog_bits,
    output logic [3:0]       rotary_channels,
    output logic             has_keycode,
    output logic             has_screen_pos,
    output logic [7:0]       screen_x_bits,
    output logic [7:0]       screen_y_bits,
    output logic [7:0]       screen_channels,
    output logic [15:0]      misc_digital,
    output logic [7:0]       card_slots,
    output logic [7:0]       hopper_channels,
    output logic [7:0]       digital_outputs,
    output logic [3:0]       analog_out_channels,
    output logic             has_char_display,
    output logic [7:0]       char_width,
    output logic [7:0]       char_height,
    output logic [7:0]       char_type,
    output logic             has_backup
);

    localparam int CNT_W = $clog2(MAX_FUNCS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FUNCS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CODE,
        S_ARG1,
        S_ARG2,
        S_ARG3,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [7:0]       code_q;
    logic [7:0]       arg1_q;
    logic [7:0]       arg2_q;
    logic [CNT_W-1:0] func_cnt;
    logic             busy;
    logic             accept;

    // Counts are 4-bit in the record; larger node claims clamp rather than wrap.
    function automatic logic [3:0] sat4(input logic [7:0] x);
        return (x > 8'd15) ? 4'hF : x[3:0];
    endfunction

    assign busy = (state == S_CODE) || (state == S_ARG1) || (state == S_ARG2) ||
                  (state == S_ARG3) || (state == S_DRAIN);

    // A restart owns the cycle it is asserted in, so no byte is taken then.
    assign in_ready = busy && !start;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            // rst and start share the clearing path; only the landing state
            // and the captured index differ.
            state               <= rst ? S_IDLE : S_CODE;
            node_idx            <= rst ? '0 : node_idx_i;
            code_q              <= 8'h00;
            arg1_q              <= 8'h00;
            arg2_q              <= 8'h00;
            func_cnt            <= '0;
            done                <= 1'b0;
            err_unknown         <= 1'b0;
            err_trunc           <= 1'b0;
            err_ovf             <= 1'b0;
            players             <= 4'h0;
            buttons             <= 8'h00;
            coin_slots          <= 4'h0;
            analog_channels     <= 4'h0;
            analog_bits         <= 8'h00;
            rotary_channels     <= 4'h0;
            has_keycode         <= 1'b0;
            has_screen_pos      <= 1'b0;
            screen_x_bits       <= 8'h00;
            screen_y_bits       <= 8'h00;
            screen_channels     <= 8'h00;
            misc_digital        <= 16'h0000;
            card_slots          <= 8'h00;
            hopper_channels     <= 8'h00;
            digital_outputs     <= 8'h00;
            analog_out_channels <= 4'h0;
            has_char_display    <= 1'b0;
            char_width          <= 8'h00;
            char_height         <= 8'h00;
            char_type           <= 8'h00;
            has_backup          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                end

                S_CODE: begin
                    if (accept) begin
                        if (in_data == 8'h00) begin
                            if (in_last) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= S_DRAIN;
                            end
                        end else if (func_cnt == MAX_CNT) begin
                            // Entry table full: flag it and skip the rest of the frame.
                            err_ovf <= 1'b1;
                            if (in_last) begin
                                err_trunc <= 1'b1;
                                state     <= S_DONE;
                                done      <= 1'b1;
                            end else begin
                                state <= S_DRAIN;
                            end
                        end else begin
                            code_q   <= in_data;
                            func_cnt <= func_cnt + CNT_W'(1);
                            if (in_last) begin
                                err_trunc <= 1'b1;
                                state     <= S_DONE;
                                done      <= 1'b1;
                            end else begin
                                state <= S_ARG1;
                            end
                        end
                    end
                end

                S_ARG1: begin
                    if (accept) begin
                        arg1_q <= in_data;
                        if (in_last) begin
                            // Partial entry is dropped: nothing committed.
                            err_trunc <= 1'b1;
                            state     <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            state <= S_ARG2;
                        end
                    end
                end

                S_ARG2: begin
                    if (accept) begin
                        arg2_q <= in_data;
                        if (in_last) begin
                            err_trunc <= 1'b1;
                            state     <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            state <= S_ARG3;
                        end
                    end
                end

                S_ARG3: begin
                    if (accept) begin
                        // Whole entry lands on this edge; arg3 is taken straight
                        // from the bus so no extra latch stage is needed.
                        case (code_q)
                            8'h01: begin
                                players <= sat4(arg1_q);
                                buttons <= arg2_q;
                            end
                            8'h02: coin_slots <= sat4(arg1_q);
                            8'h03: begin
                                analog_channels <= sat4(arg1_q);
                                analog_bits     <= arg2_q;
                            end
                            8'h04: rotary_channels <= sat4(arg1_q);
                            8'h05: has_keycode <= 1'b1;
                            8'h06: begin
                                has_screen_pos  <= 1'b1;
                                screen_x_bits   <= arg1_q;
                                screen_y_bits   <= arg2_q;
                                screen_channels <= in_data;
                            end
                            8'h07: misc_digital <= {arg1_q, arg2_q};
                            8'h10: card_slots <= arg1_q;
                            8'h11: hopper_channels <= arg1_q;
                            8'h12: digital_outputs <= arg1_q;
                            8'h13: analog_out_channels <= sat4(arg1_q);
                            8'h14: begin
                                has_char_display <= 1'b1;
                                char_width       <= arg1_q;
                                char_height      <= arg2_q;
                                char_type        <= in_data;
                            end
                            8'h15: has_backup <= 1'b1;
                            default: err_unknown <= 1'b1;
                        endcase
                        if (in_last) begin
                            // Complete entry but no terminator followed it.
                            err_trunc <= 1'b1;
                            state     <= S_DONE;
                            done      <= 1'b1;
                        end else begin
                            state <= S_CODE;
                        end
                    end
                end

                S_DRAIN: begin
                    if (accept && in_last) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jvs_feature_parser.sv
// tb/tb_jvs_feature_parser.sv - directed self-checking bench for jvs_feature_parser

module tb_jvs_feature_parser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid, in_last;
    logic [0:0] node_idx_i;
    logic [7:0] in_data;

    logic       in_ready, done, err_unknown, err_trunc, err_ovf;
    logic [0:0] node_idx;
    logic [3:0] players, coin_slots, analog_channels, rotary_channels, analog_out_channels;
    logic [7:0] buttons, analog_bits, screen_x_bits, screen_y_bits, screen_channels;
    logic [7:0] card_slots, hopper_channels, digital_outputs, char_width, char_height, char_type;
    logic [15:0] misc_digital;
    logic       has_keycode, has_screen_pos, has_char_display, has_backup;

    logic       v_in_ready, v_done, v_err_unknown, v_err_trunc, v_err_ovf;
    logic [0:0] v_node_idx;
    logic [3:0] v_players, v_coin_slots, v_analog_channels, v_rotary_channels, v_analog_out_channels;
    logic [7:0] v_buttons, v_analog_bits, v_screen_x_bits, v_screen_y_bits, v_screen_channels;
    logic [7:0] v_card_slots, v_hopper_channels, v_digital_outputs, v_char_width, v_char_height, v_char_type;
    logic [15:0] v_misc_digital;
    logic       v_has_keycode, v_has_screen_pos, v_has_char_display, v_has_backup;

    jvs_feature_parser #(.MAX_FUNCS(16), .IDX_W(1)) dut (
        .clk(clk), .rst(rst), .start(start), .node_idx_i(node_idx_i),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .node_idx(node_idx), .done(done), .err_unknown(err_unknown),
        .err_trunc(err_trunc), .err_ovf(err_ovf),
        .players(players), .buttons(buttons), .coin_slots(coin_slots),
        .analog_channels(analog_channels), .analog_bits(analog_bits),
        .rotary_channels(rotary_channels), .has_keycode(has_keycode),
        .has_screen_pos(has_screen_pos), .screen_x_bits(screen_x_bits),
        .screen_y_bits(screen_y_bits), .screen_channels(screen_channels),
        .misc_digital(misc_digital), .card_slots(card_slots),
        .hopper_channels(hopper_channels), .digital_outputs(digital_outputs),
        .analog_out_channels(analog_out_channels), .has_char_display(has_char_display),
        .char_width(char_width), .char_height(char_height), .char_type(char_type),
        .has_backup(has_backup)
    );

    jvs_feature_parser #(.MAX_FUNCS(2), .IDX_W(1)) dut_small (
        .clk(clk), .rst(rst), .start(start), .node_idx_i(node_idx_i),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(v_in_ready),
        .node_idx(v_node_idx), .done(v_done), .err_unknown(v_err_unknown),
        .err_trunc(v_err_trunc), .err_ovf(v_err_ovf),
        .players(v_players), .buttons(v_buttons), .coin_slots(v_coin_slots),
        .analog_channels(v_analog_channels), .analog_bits(v_analog_bits),
        .rotary_channels(v_rotary_channels), .has_keycode(v_has_keycode),
        .has_screen_pos(v_has_screen_pos), .screen_x_bits(v_screen_x_bits),
        .screen_y_bits(v_screen_y_bits), .screen_channels(v_screen_channels),
        .misc_digital(v_misc_digital), .card_slots(v_card_slots),
        .hopper_channels(v_hopper_channels), .digital_outputs(v_digital_outputs),
        .analog_out_channels(v_analog_out_channels), .has_char_display(v_has_char_display),
        .char_width(v_char_width), .char_height(v_char_height), .char_type(v_char_type),
        .has_backup(v_has_backup)
    );

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    int v_done_cnt = 0;
    int dc;
    logic [7:0] q[$];

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (v_done) v_done_cnt <= v_done_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic do_start(input logic [0:0] idx);
        @(negedge clk);
        start = 1'b1; node_idx_i = idx;
        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
        #1 chk("start_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [7:0] d, input logic l);
        bit got;
        got = 1'b0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int k = 0; k < 20; k++) begin
            #1 got = in_ready;
            @(posedge clk);
            @(negedge clk);
            if (got) break;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input bit gaps);
        for (int i = 0; i < q.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send(q[i], i == q.size() - 1);
        end
        chk("done_latency", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic chk_nominal();
        chk("t1_players", players, 2);
        chk("t1_buttons", buttons, 13);
        chk("t1_coin_slots", coin_slots, 2);
        chk("t1_analog_ch", analog_channels, 8);
        chk("t1_analog_bits", analog_bits, 10);
        chk("t1_node_idx", node_idx, 1);
        chk("t1_errs", {err_unknown, err_trunc, err_ovf}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; node_idx_i = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_errs", {err_unknown, err_trunc, err_ovf}, 0);
        chk("rst_players", players, 0);
        chk("rst_node_idx", node_idx, 0);

        // 1: nominal
        do_start(1'b1);
        q = '{8'h01, 8'h02, 8'h0D, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00,
              8'h03, 8'h08, 8'h0A, 8'h00, 8'h00};
        run(1'b0);
        chk_nominal();

        // 2: saturation, misc digital, screen position
        do_start(1'b0);
        q = '{8'h01, 8'h14, 8'h08, 8'h00, 8'h07, 8'h01, 8'h20, 8'h00,
              8'h06, 8'h0A, 8'h09, 8'h01, 8'h00};
        run(1'b0);
        chk("t2_players_sat", players, 15);
        chk("t2_buttons", buttons, 8);
        chk("t2_misc", misc_digital, 16'h0120);
        chk("t2_screen", {has_screen_pos, screen_x_bits, screen_y_bits, screen_channels},
            {1'b1, 8'd10, 8'd9, 8'd1});
        chk("t2_coin_cleared", coin_slots, 0);
        chk("t2_node_idx", node_idx, 0);

        // 3: unknown code, duplicate, trailing bytes after terminator
        do_start(1'b1);
        q = '{8'h3F, 8'h01, 8'h02, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00,
              8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        run(1'b0);
        chk("t3_err_unknown", err_unknown, 1);
        chk("t3_coin_dup", coin_slots, 3);
        chk("t3_err_trunc", err_trunc, 0);
        chk("t3_players", players, 0);

        // 4a: truncated inside arguments
        do_start(1'b0);
        q = '{8'h03, 8'h04};
        run(1'b0);
        chk("t4a_err_trunc", err_trunc, 1);
        chk("t4a_analog", {analog_channels, analog_bits}, 0);

        // 4b: full entry but no terminator
        do_start(1'b0);
        q = '{8'h12, 8'h05, 8'h00, 8'h00};
        run(1'b0);
        chk("t4b_dout", digital_outputs, 5);
        chk("t4b_err_trunc", err_trunc, 1);

        // 5: overflow on the MAX_FUNCS=2 instance
        do_start(1'b0);
        dc = v_done_cnt;
        for (int e = 0; e < 2; e++) begin
            send(8'h15, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        end
        chk("t5_ovf_before", v_err_ovf, 0);
        send(8'h15, 1'b0);
        chk("t5_ovf_third_code", v_err_ovf, 1);
        send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        chk("t5_small_done", v_done, 1);
        chk("t5_big_done", done, 1);
        @(negedge clk);
        chk("t5_small_backup", v_has_backup, 1);
        chk("t5_small_trunc", v_err_trunc, 0);
        chk("t5_small_done_cnt", v_done_cnt - dc, 1);
        chk("t5_big_ovf", err_ovf, 0);
        chk("t5_big_backup", has_backup, 1);

        // 6a: restart while in ARG2
        do_start(1'b1);
        send(8'h01, 1'b0); send(8'h03, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        chk("t6a_players_pre", players, 3);
        send(8'h02, 1'b0); send(8'h04, 1'b0);
        dc = done_cnt;
        do_start(1'b0);
        chk("t6a_players_clr", players, 0);
        chk("t6a_node_idx", node_idx, 0);
        q = '{8'h02, 8'h05, 8'h00, 8'h00, 8'h00};
        run(1'b0);
        chk("t6a_coin", coin_slots, 5);
        chk("t6a_done_cnt", done_cnt - dc, 1);

        // 6b: reset mid-stream
        do_start(1'b1);
        send(8'h01, 1'b0); send(8'h03, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        dc = done_cnt;
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h07;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("t6b_players", players, 0);
        chk("t6b_in_ready", in_ready, 0);
        chk("t6b_node_idx", node_idx, 0);
        @(negedge clk);
        chk("t6b_no_done", done_cnt - dc, 0);

        // 6c: scenario 1 with random in_valid gaps
        do_start(1'b1);
        q = '{8'h01, 8'h02, 8'h0D, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00,
              8'h03, 8'h08, 8'h0A, 8'h00, 8'h00};
        run(1'b1);
        chk_nominal();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
